// File: rtl/barrel_normalizer.sv
// Multi-cycle normalizer: counts leading (dir=0) or trailing (dir=1) zeros and
// justifies the operand, resolving one power-of-two shift stage per clock.
module barrel_normalizer #(
  parameter int WIDTH = 32,
  localparam int LOG = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LOG-1:0]   shamt_o,
  output logic             zero_o,
  output logic [1:0]       state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // source holds valid and payload stable until then, the sink may raise ready freely.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [LOG-1:0]   shamt_q;
  logic [LOG-1:0]   stage_q;
  logic             zero_q;
  logic             dir_q;

  logic [LOG:0]     span;
  logic [LOG:0]     rest;
  logic             hit;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = SHIFT;
      SHIFT:   if (stage_q == '0) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    state_o     = state_q;
  end

  // Stage s examines the 2^s bits at the leading edge; if they are all zero
  // the operand moves by 2^s and bit s of the count is set.
  always_comb begin
    span = (LOG+1)'(1) << stage_q;
    rest = (LOG+1)'(WIDTH) - span;
    if (!dir_q) begin
      hit     = ((work_q >> rest) == '0);
      shifted = work_q << span;
    end else begin
      hit     = ((work_q << rest) == '0);
      shifted = work_q >> span;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      work_q  <= '0;
      shamt_q <= '0;
      stage_q <= '0;
      zero_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            work_q  <= data_i;
            dir_q   <= dir_i;
            zero_q  <= (data_i == '0);
            shamt_q <= '0;
            stage_q <= LOG'(LOG - 1);
          end
        end
        SHIFT: begin
          if (hit) begin
            work_q           <= shifted;
            shamt_q[stage_q] <= 1'b1;
          end
          if (stage_q != '0) stage_q <= stage_q - LOG'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_o  = work_q;
  assign shamt_o = shamt_q;
  assign zero_o  = zero_q;

endmodule
